// File: rtl/fp_add_seq_pkg.sv
// Shared types and constants for the sequential FP adder: FSM state
// encoding, IEEE-754 single constants and the special-value resolver.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          MANT_W  = 27;

    // Result for any operation involving NaN or infinity; signs are the
    // effective signs (y already inverted for subtraction).
    function automatic logic [31:0] special_result(
        input logic x_inf,
        input logic y_inf,
        input logic x_nan,
        input logic y_nan,
        input logic x_sign,
        input logic y_sign
    );
        logic [31:0] res;
        if (x_nan || y_nan)
            res = QNAN;
        else if (x_inf && y_inf && (x_sign != y_sign))
            res = QNAN;
        else if (x_inf)
            res = {x_sign, EXP_MAX, 23'd0};
        else
            res = {y_sign, EXP_MAX, 23'd0};
        return res;
    endfunction

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq. Signal suffixes are
// relative to the core (slave side).
interface fp_add_seq_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        sub_i;
    logic        x_sign_i;
    logic        y_sign_i;
    logic [7:0]  x_exp_i;
    logic [7:0]  y_exp_i;
    logic [22:0] x_frac_i;
    logic [22:0] y_frac_i;
    logic        x_greater_i;
    logic [7:0]  exp_shift_i;
    logic        x_inf_i;
    logic        y_inf_i;
    logic        x_nan_i;
    logic        y_nan_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        overflow_o;

    modport slave (
        input  in_valid_i, sub_i, x_sign_i, y_sign_i, x_exp_i, y_exp_i,
               x_frac_i, y_frac_i, x_greater_i, exp_shift_i,
               x_inf_i, y_inf_i, x_nan_i, y_nan_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, overflow_o
    );

    modport master (
        output in_valid_i, sub_i, x_sign_i, y_sign_i, x_exp_i, y_exp_i,
               x_frac_i, y_frac_i, x_greater_i, exp_shift_i,
               x_inf_i, y_inf_i, x_nan_i, y_nan_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, overflow_o
    );
endinterface

// File: rtl/fp_add_seq_round.sv
// fp_round: combinational GRS rounder and final IEEE-754 packer.
// FPU_ROUND_EN defined -> round-to-nearest-even, else truncate.
// Input mantissa: [26] hidden, [25:3] fraction, [2] G, [1] R, [0] sticky.
module fp_round
    import fpu_pkg::*;
(
    input  logic              i_sign,
    input  logic [9:0]        i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output logic [31:0]       o_result,
    output logic              o_overflow
);

    logic        w_up;
    logic [24:0] w_rnd;
    logic [9:0]  w_exp;
    logic        w_hid;
    logic [22:0] w_frac;

`ifdef FPU_ROUND_EN
    // Round up on G when the tail is above half or the result LSB is odd.
    always_comb begin
        w_up = i_mant[2] && (i_mant[1] || i_mant[0] || i_mant[3]);
    end
`else
    logic w_unused_grs;
    // Truncation: guard/round/sticky are simply dropped.
    always_comb begin
        w_up         = 1'b0;
        w_unused_grs = ^i_mant[2:0];
    end
`endif

    // Apply increment, fix up carry-out, then pick inf / subnormal / normal.
    always_comb begin
        w_rnd  = {1'b0, i_mant[26:3]} + {24'd0, w_up};
        w_exp  = i_exp;
        w_hid  = w_rnd[23];
        w_frac = w_rnd[22:0];
        if (w_rnd[24]) begin
            w_exp  = i_exp + 10'd1;
            w_hid  = 1'b1;
            w_frac = 23'd0;
        end
        o_overflow = 1'b0;
        if (w_exp >= 10'd255) begin
            o_result   = {i_sign, EXP_MAX, 23'd0};
            o_overflow = 1'b1;
        end else if (!w_hid) begin
            o_result = {i_sign, 8'd0, w_frac};
        end else begin
            o_result = {i_sign, w_exp[7:0], w_frac};
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// fp_add_seq: iterative single-precision add/subtract. One alignment bit
// per cycle, one normalization bit per cycle, then a rounding cycle.
// Rounding mode selected by FPU_ROUND_EN (see fp_round).
module fp_add_seq
    import fpu_pkg::*;
#(
    parameter int MAX_ALIGN = 26
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    fp_add_seq_if.slave bus
);

    localparam logic [7:0] MAX_N = 8'(MAX_ALIGN);

    state_t             r_state, w_next;
    logic               r_sa, r_sb, r_sign, r_ovf;
    logic [MANT_W-1:0]  r_ma, r_mb;
    logic [MANT_W:0]    r_mant;
    logic [9:0]         r_exp;
    logic [7:0]         r_cnt;
    logic [31:0]        r_result;

    logic               w_ys_eff, w_special, w_big;
    logic [MANT_W-1:0]  w_xm, w_ym, w_b_raw, w_b_ld;
    logic [7:0]         w_xe, w_ye, w_n;
    logic [MANT_W:0]    w_sum, w_nmant;
    logic [9:0]         w_nexp;
    logic [31:0]        w_rnd_res;
    logic               w_rnd_ovf;

    // More normalization needed: carry out, or unnormalized above min exponent.
    function automatic logic needs_norm(input logic [MANT_W:0] m, input logic [9:0] e);
        return m[27] || (!m[26] && (e > 10'd1));
    endfunction

    // Operand unpacking, alignment load and the add/normalize step values.
    always_comb begin
        w_ys_eff  = bus.y_sign_i ^ bus.sub_i;
        w_special = bus.x_inf_i | bus.y_inf_i | bus.x_nan_i | bus.y_nan_i;
        w_xm      = {(bus.x_exp_i != 8'd0), bus.x_frac_i, 3'b000};
        w_ym      = {(bus.y_exp_i != 8'd0), bus.y_frac_i, 3'b000};
        w_xe      = (bus.x_exp_i == 8'd0) ? 8'd1 : bus.x_exp_i;
        w_ye      = (bus.y_exp_i == 8'd0) ? 8'd1 : bus.y_exp_i;
        w_big     = bus.exp_shift_i > MAX_N;
        w_n       = w_big ? MAX_N : bus.exp_shift_i;
        w_b_raw   = bus.x_greater_i ? w_ym : w_xm;
        // Shifts beyond the cap would lose everything but sticky anyway.
        w_b_ld    = w_big ? {{(MANT_W-1){1'b0}}, |w_b_raw} : w_b_raw;
        w_sum     = (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                   : ({1'b0, r_ma} - {1'b0, r_mb});
        if (r_mant[27]) begin
            w_nmant = {1'b0, r_mant[27:2], r_mant[1] | r_mant[0]};
            w_nexp  = r_exp + 10'd1;
        end else begin
            w_nmant = {r_mant[26:0], 1'b0};
            w_nexp  = r_exp - 10'd1;
        end
    end

    fp_round u_round (
        .i_sign     (r_sign),
        .i_exp      (r_exp),
        .i_mant     (r_mant[MANT_W-1:0]),
        .o_result   (w_rnd_res),
        .o_overflow (w_rnd_ovf)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid_i)
                         w_next = w_special ? S_DONE : ((w_n != 8'd0) ? S_ALIGN : S_ADD);
            S_ALIGN: if (r_cnt == 8'd1) w_next = S_ADD;
            S_ADD:   w_next = ((w_sum != '0) && needs_norm(w_sum, r_exp)) ? S_NORM : S_ROUND;
            S_NORM:  w_next = needs_norm(w_nmant, w_nexp) ? S_NORM : S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; result held in registers.
    always_comb begin
        bus.in_ready_o  = (r_state == S_IDLE);
        bus.out_valid_o = (r_state == S_DONE);
        bus.result_o    = r_result;
        bus.overflow_o  = r_ovf;
    end

    // Datapath registers advanced per state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_sign   <= 1'b0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_mant   <= '0;
            r_exp    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid_i) begin
                    r_sa   <= bus.x_greater_i ? bus.x_sign_i : w_ys_eff;
                    r_sb   <= bus.x_greater_i ? w_ys_eff : bus.x_sign_i;
                    r_ma   <= bus.x_greater_i ? w_xm : w_ym;
                    r_mb   <= w_b_ld;
                    r_exp  <= {2'b00, bus.x_greater_i ? w_xe : w_ye};
                    r_cnt  <= w_n;
                    r_ovf  <= 1'b0;
                    if (w_special)
                        r_result <= special_result(bus.x_inf_i, bus.y_inf_i, bus.x_nan_i,
                                                   bus.y_nan_i, bus.x_sign_i, w_ys_eff);
                end
                S_ALIGN: begin
                    r_mb  <= {1'b0, r_mb[MANT_W-1:2], r_mb[1] | r_mb[0]};
                    r_cnt <= r_cnt - 8'd1;
                end
                S_ADD: begin
                    r_mant <= w_sum;
                    r_sign <= (w_sum == '0) ? (r_sa & r_sb) : r_sa;
                end
                S_NORM: begin
                    r_mant <= w_nmant;
                    r_exp  <= w_nexp;
                end
                S_ROUND: begin
                    r_result <= w_rnd_res;
                    r_ovf    <= w_rnd_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed testbench for fp_add_seq: reset state, arithmetic vectors with
// latency, rounding, specials, back-to-back, backpressure, mid-op reset.
module tb_fp_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fp_add_seq_if bus();

    fp_add_seq #(.MAX_ALIGN(26)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Drive one operand bundle (decomposed here), accept it, and wait for
    // out_valid. lat = edges after acceptance edge until out_valid seen.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                          output logic [31:0] res, output logic ovf, output int lat,
                          output logic rdy_busy);
        logic [7:0] xee, yee;
        @(negedge clk);
        xee = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        yee = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        bus.sub_i       = sub;
        bus.x_sign_i    = x[31];
        bus.y_sign_i    = y[31];
        bus.x_exp_i     = x[30:23];
        bus.y_exp_i     = y[30:23];
        bus.x_frac_i    = x[22:0];
        bus.y_frac_i    = y[22:0];
        bus.x_greater_i = x[30:0] > y[30:0];
        bus.exp_shift_i = (x[30:0] > y[30:0]) ? (xee - yee) : (yee - xee);
        bus.x_inf_i     = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        bus.y_inf_i     = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        bus.x_nan_i     = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        bus.y_nan_i     = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        bus.in_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        rdy_busy = bus.in_ready_o;
        lat = 0;
        while (!bus.out_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result_o;
        ovf = bus.overflow_o;
    endtask

    // Let the output handshake complete (out_ready_i assumed high).
    task automatic finish_op();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        checks++;
        if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        checks++;
        if (bus.result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 00000000", bus.result_o); end
        checks++;
        if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [31:0] tx [0:7];
        logic [31:0] ty [0:7];
        logic        ts [0:7];
        logic [31:0] te [0:7];
        logic        to [0:7];
        int          tl [0:7];
        logic [31:0] res;
        logic        ovf, rb;
        int          lat;
        tx = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'hBF800000,
               32'h00000001, 32'h80000000, 32'h7F7FFFFF, 32'h3F800000};
        ty = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
               32'h00000001, 32'h80000000, 32'h7F7FFFFF, 32'h33800000};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        te = '{32'h40000000, 32'h00000000, 32'h3F000000, 32'hC0000000,
               32'h00000002, 32'h80000000, 32'h7F800000, 32'h3F800000};
        to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tl = '{3, 2, 3, 3, 2, 2, 3, 26};
        for (int i = 0; i < 8; i++) begin
            run_op(tx[i], ty[i], ts[i], res, ovf, lat, rb);
            checks++;
            if (res !== te[i]) begin failures++; $display("FAIL arith%0d_result: got %h want %h", i, res, te[i]); end
            checks++;
            if (ovf !== to[i]) begin failures++; $display("FAIL arith%0d_overflow: got %b want %b", i, ovf, to[i]); end
            checks++;
            if (lat != tl[i]) begin failures++; $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            checks++;
            if (rb !== 1'b0) begin failures++; $display("FAIL arith%0d_busy_ready: got %b want 0", i, rb); end
            finish_op();
        end
    endtask

    task automatic test_round();
        logic [31:0] res, want;
        logic        ovf, rb;
        int          lat;
`ifdef FPU_ROUND_EN
        want = 32'h3F800001;
`else
        want = 32'h3F800000;
`endif
        run_op(32'h3F800000, 32'h33C00000, 1'b0, res, ovf, lat, rb);
        checks++;
        if (res !== want) begin failures++; $display("FAIL round_result: got %h want %h", res, want); end
        checks++;
        if (lat != 26) begin failures++; $display("FAIL round_latency: got %0d want 26", lat); end
        finish_op();
    endtask

    task automatic test_specials();
        logic [31:0] tx [0:3];
        logic [31:0] ty [0:3];
        logic        ts [0:3];
        logic [31:0] te [0:3];
        logic [31:0] res;
        logic        ovf, rb;
        int          lat;
        tx = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h3F800000};
        ty = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
        ts = '{1'b0, 1'b0, 1'b0, 1'b1};
        te = '{32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000};
        for (int i = 0; i < 4; i++) begin
            run_op(tx[i], ty[i], ts[i], res, ovf, lat, rb);
            checks++;
            if (res !== te[i]) begin failures++; $display("FAIL special%0d_result: got %h want %h", i, res, te[i]); end
            checks++;
            if (lat != 0) begin failures++; $display("FAIL special%0d_latency: got %0d want 0", i, lat); end
            checks++;
            if (ovf !== 1'b0) begin failures++; $display("FAIL special%0d_overflow: got %b want 0", i, ovf); end
            finish_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        ovf, rb;
        int          lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ovf, lat, rb);
        finish_op();
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready_o, bus.out_valid_o);
        end
        run_op(32'h3FC00000, 32'h3F800000, 1'b1, res, ovf, lat, rb);
        checks++;
        if (res !== 32'h3F000000) begin failures++; $display("FAIL b2b_result: got %h want 3F000000", res); end
        finish_op();
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        ovf, rb;
        int          lat;
        bus.out_ready_i = 1'b0;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ovf, lat, rb);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.result_o !== 32'h40000000 || bus.in_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b res=%h rdy=%b want vld=1 res=40000000 rdy=0",
                         k, bus.out_valid_o, bus.result_o, bus.in_ready_o);
            end
        end
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        finish_op();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        ovf, rb;
        int          lat;
        @(negedge clk);
        bus.sub_i = 1'b0; bus.x_sign_i = 1'b0; bus.y_sign_i = 1'b0;
        bus.x_exp_i = 8'h7F; bus.y_exp_i = 8'h67;
        bus.x_frac_i = 23'd0; bus.y_frac_i = 23'h400000;
        bus.x_greater_i = 1'b1; bus.exp_shift_i = 8'd24;
        bus.x_inf_i = 1'b0; bus.y_inf_i = 1'b0; bus.x_nan_i = 1'b0; bus.y_nan_i = 1'b0;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid_o, bus.in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ovf, lat, rb);
        checks++;
        if (res !== 32'h40000000 || lat != 3) begin
            failures++;
            $display("FAIL midreset_recover: got %h lat %0d want 40000000 lat 3", res, lat);
        end
        finish_op();
    endtask

    initial begin
        bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1; bus.sub_i = 1'b0;
        bus.x_sign_i = 1'b0; bus.y_sign_i = 1'b0; bus.x_exp_i = '0; bus.y_exp_i = '0;
        bus.x_frac_i = '0; bus.y_frac_i = '0; bus.x_greater_i = 1'b0; bus.exp_shift_i = '0;
        bus.x_inf_i = 1'b0; bus.y_inf_i = 1'b0; bus.x_nan_i = 1'b0; bus.y_nan_i = 1'b0;
        test_reset();
        test_arith();
        test_round();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle IEEE-754 single-precision add/subtract core. It sits directly downstream of the `operands` decomposition stage and consumes its sign, exponent, fraction, magnitude-compare, shift and special-value outputs. It uses an iterative datapath: one alignment bit per cycle, then one normalization bit per cycle. It returns a packed 32-bit result over a valid/ready handshake.

## Interface
Parameters:
- `MAX_ALIGN`, default 26: cap on alignment shift cycles. Beyond this, all shifted-out bits go to sticky.

Ports:
- `clk_i`, in, 1: clock. Rising edge.
- `rst_n_i`, in, 1: reset. Asynchronous assert, active-low.
- `in_valid_i`, in, 1: operand bundle valid.
- `in_ready_o`, out, 1: core idle and able to accept.
- `sub_i`, in, 1: 1 computes x − y (inverts y sign).
- `x_sign_i`, `y_sign_i`, in, 1 each: operand signs.
- `x_exp_i`, `y_exp_i`, in, 8 each: biased exponents.
- `x_frac_i`, `y_frac_i`, in, 23 each: stored fractions.
- `x_greater_i`, in, 1: |x| > |y|.
- `exp_shift_i`, in, 8: exponent difference, larger minus smaller.
- `x_inf_i`, `y_inf_i`, `x_nan_i`, `y_nan_i`, in, 1 each: special-value flags.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: consumer accepts.
- `result_o`, out, 32: packed result.
- `overflow_o`, out, 1: finite inputs produced ±inf. Qualified by `out_valid_o`.

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- Reset: state IDLE; `out_valid_o`=0; `result_o`=0; `overflow_o`=0; `in_ready_o`=1 (decoded from IDLE).
- IDLE, on `in_valid_i`:
  - Capture operands and set effective y sign = `y_sign_i ^ sub_i`.
  - Build 27-bit mantissas: hidden bit, 23-bit fraction, 3 GRS bits = 0. Hidden bit = (exp≠0). Effective exponent = max(exp,1).
  - The larger operand (per `x_greater_i`) is A; the other is B. Result exponent = A's effective exponent.
  - Load shift counter with N = min(`exp_shift_i`, `MAX_ALIGN`).
  - Next state: DONE if any special flag is set; else ALIGN if N>0; else ADD.
- Specials (DONE directly):
  - Any NaN → 0x7FC00000.
  - inf ± inf with differing effective signs → 0x7FC00000.
  - Otherwise inf with its effective sign.
- ALIGN: each cycle, B >>= 1, bit shifted out ORed into sticky (bit 0), counter decrements. Exit to ADD when the counter reaches 0. If `exp_shift_i` exceeds `MAX_ALIGN`, B collapses to sticky only.
- ADD:
  - Same effective signs: 28-bit sum = A + B, sign of A.
  - Different effective signs: A − B, sign of A.
  - Exact zero result → +0, or −0 only if both effective signs are negative. Zero goes straight to ROUND.
- NORM:
  - Carry set: one right shift with sticky retained, exponent+1, one cycle.
  - Else, while bit 26 = 0 and exponent > 1: left shift, exponent−1, one cycle each.
  - M = cycles spent here.
- ROUND: rounding per Configuration.
  - Mantissa carry-out on rounding → exponent+1, mantissa reset to 1.0.
  - Exponent ≥ 255 → ±inf, `overflow_o`=1.
  - Bit 26 = 0 at exponent 1 → subnormal encoding, exponent field 0.
- DONE: `out_valid_o`=1. `result_o` and `overflow_o` are stable until `out_valid_o && out_ready_i`, then return to IDLE.

## Timing
- Acceptance edge: e0.
- Normal path: `out_valid_o` high from edge e0+N+M+2.
- Special path: `out_valid_o` high from e0 (1 cycle).
- Worst case is 26+24+2 cycles.
- `in_ready_o` is low from e0 until the edge after the output handshake completes. There is no overlap between operations.
- The `in_valid_i`, `out_ready_i` handshake can complete in the same cycle as DONE. The next accept happens no earlier than the following cycle.
- Reset mid-operation: immediate return to IDLE, `out_valid_o`=0, and the in-flight operation is discarded.

## Configuration
- `FPU_ROUND_EN` defined: round-to-nearest-even from G/R/sticky. Round up when G && (R || S || LSB).
- `FPU_ROUND_EN` undefined: truncate (round toward zero). The ROUND state still occupies one cycle, so latency is identical.

## Structure
- `fpu_pkg` holds:
  - the state enum;
  - constants QNAN = 32'h7FC00000, EXP_MAX = 8'hFF, MANT_W = 27;
  - the special-value decode function.
- Sub-module `fp_round`: combinational GRS rounder plus overflow and subnormal packing, used in ROUND.

## Test plan
- 0x3F800000 + 0x3F800000: N=0, M=1 → 0x40000000 at e0+3.
- 0x3F800000 − 0x3F800000 (`sub_i`=1) → 0x00000000 at e0+2.
- 0x3F800000 + 0x33C00000:
  - with `FPU_ROUND_EN` → 0x3F800001;
  - without → 0x3F800000;
  - both after 24 ALIGN cycles.
- 0x3F800000 + 0x33800000 (exact tie) with `FPU_ROUND_EN` → 0x3F800000 (ties to even).
- 0x7F800000 + 0xFF800000 → 0x7FC00000 at e0.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with `overflow_o`=1.
- Backpressure and reset:
  - Hold `out_ready_i`=0 for 5 cycles → result stable and `in_ready_o`=0.
  - Assert `rst_n_i` low during ALIGN → IDLE with `out_valid_o`=0.
